// File: rtl/traffic_pkg.sv
// traffic_pkg
// Shared definitions for the intersection phase scheduler: lamp codes,
// state encodings (also driven out on the debug phase bus) and direction codes.
package traffic_pkg;

  // Lamp bus codes, bit order {red, yellow, green}
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  // Direction codes for emerg_dir and next_dir
  localparam logic DIR_A = 1'b0;
  localparam logic DIR_B = 1'b1;

  // Phase codes; the numeric values are visible on the phase output
  typedef enum logic [2:0] {
    A_GRN = 3'd0,
    A_YEL = 3'd1,
    AR_AB = 3'd2,
    B_GRN = 3'd3,
    B_YEL = 3'd4,
    AR_BA = 3'd5,
    WALK  = 3'd6
  } state_t;

  // Green phase serving the given direction
  function automatic state_t green_of(input logic dir);
    return (dir == DIR_B) ? B_GRN : A_GRN;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// phase_timer
// 8-bit saturating up-counter measuring time spent in the current phase.
// Ports:
//   clk   - system clock (1 Hz tick)
//   reset - synchronous, active-high; forces count to 0
//   clr   - synchronous clear, asserted on the edge that changes phase
//   count - cycles elapsed in the current phase, sticks at 255
module phase_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  output logic [7:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= 8'd0;
    end else if (count != 8'hFF) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler
// Demand-driven phase sequencer for a two-road intersection (main road A,
// side road B) with an all-way pedestrian WALK phase and emergency preemption.
// Ports:
//   clk       - system clock, 1 Hz tick (one cycle = one second)
//   reset     - synchronous, active-high
//   car_a     - vehicle waiting on road A (level)
//   car_b     - vehicle waiting on road B (level)
//   ped_req   - pedestrian button (pulse or level)
//   emerg_req - emergency preemption request (level)
//   emerg_dir - preempted direction, 0 = A, 1 = B
//   light_A   - road A lamps {red, yellow, green}
//   light_B   - road B lamps {red, yellow, green}
//   walk      - pedestrian walk lamp
//   phase     - current state code for debug/monitoring
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN = 5,
  parameter int GREEN_MAX = 10,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       car_a,
  input  logic       car_b,
  input  logic       ped_req,
  input  logic       emerg_req,
  input  logic       emerg_dir,
  output logic [2:0] light_A,
  output logic [2:0] light_B,
  output logic       walk,
  output logic [2:0] phase
);

  // Timer values seen in the last cycle of each timed interval
  localparam logic [7:0] GMIN_LAST   = 8'(GREEN_MIN - 1);
  localparam logic [7:0] GMAX_LAST   = 8'(GREEN_MAX - 1);
  localparam logic [7:0] YEL_LAST    = 8'(YELLOW_T - 1);
  localparam logic [7:0] ALLRED_LAST = 8'(ALLRED_T - 1);
  localparam logic [7:0] WALK_LAST   = 8'(WALK_T - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] t;
  logic       clr;
  logic       ped_pend;
  logic       next_dir;
  logic       emerg_a;
  logic       emerg_b;

  assign emerg_a = emerg_req && (emerg_dir == DIR_A);
  assign emerg_b = emerg_req && (emerg_dir == DIR_B);
  assign clr     = (state_next != state);

  phase_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .count (t)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= A_GRN;
    end else begin
      state <= state_next;
    end
  end

  // Yellow is never shortened; only greens and WALK react to preemption.
  always_comb begin
    state_next = state;
    case (state)
      A_GRN: begin
        if (emerg_b || (!emerg_a && (t >= GMIN_LAST) && (car_b || ped_pend))) begin
          state_next = A_YEL;
        end
      end
      A_YEL: begin
        if (t == YEL_LAST) state_next = AR_AB;
      end
      B_GRN: begin
        if (emerg_a ||
            (!emerg_b && (t >= GMIN_LAST) &&
             (!car_b || ped_pend || (car_a && (t >= GMAX_LAST))))) begin
          state_next = B_YEL;
        end
      end
      B_YEL: begin
        if (t == YEL_LAST) state_next = AR_BA;
      end
      AR_AB, AR_BA: begin
        if (t == ALLRED_LAST) begin
          if (emerg_req)     state_next = green_of(emerg_dir);
          else if (ped_pend) state_next = WALK;
          else               state_next = green_of(next_dir);
        end
      end
      WALK: begin
        if (emerg_req)            state_next = green_of(emerg_dir);
        else if (t == WALK_LAST)  state_next = green_of(next_dir);
      end
      default: state_next = A_GRN;
    endcase
  end

  // next_dir latches on entry to each all-red: the road that was not just
  // served is the one a WALK hands over to.
  always_ff @(posedge clk) begin
    if (reset) begin
      ped_pend <= 1'b0;
      next_dir <= DIR_B;
    end else begin
      if (state_next == WALK && state != WALK) begin
        ped_pend <= 1'b0;
      end else if (ped_req && state != WALK) begin
        ped_pend <= 1'b1;
      end
      if (state_next == AR_AB && state != AR_AB) begin
        next_dir <= DIR_B;
      end else if (state_next == AR_BA && state != AR_BA) begin
        next_dir <= DIR_A;
      end
    end
  end

  always_comb begin
    light_A = RED;
    light_B = RED;
    walk    = 1'b0;
    case (state)
      A_GRN:   light_A = GREEN;
      A_YEL:   light_A = YELLOW;
      B_GRN:   light_B = GREEN;
      B_YEL:   light_B = YELLOW;
      WALK:    walk    = 1'b1;
      default: ;
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb_traffic_phase_scheduler
// Directed scenarios with hand-computed phase timelines, followed by a long
// randomized run; a behavioural model of the intersection rules tracks the
// expected phase every second and a compare process checks the DUT against it.
module tb_traffic_phase_scheduler;

  localparam int GREEN_MIN = 5;
  localparam int GREEN_MAX = 10;
  localparam int YELLOW_T  = 2;
  localparam int ALLRED_T  = 1;
  localparam int WALK_T    = 4;

  localparam int PH_AG = 0, PH_AY = 1, PH_ARAB = 2, PH_BG = 3;
  localparam int PH_BY = 4, PH_ARBA = 5, PH_WALK = 6;

  logic       clk;
  logic       reset;
  logic       car_a, car_b, ped_req, emerg_req, emerg_dir;
  logic [2:0] light_A, light_B;
  logic       walk;
  logic [2:0] phase;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 0;

  // Model: which phase is lit, seconds already spent in it, pending button,
  // and the road to serve after the next all-red (1 = B).
  int m_phase = PH_AG;
  int m_t     = 0;
  bit m_ped   = 0;
  bit m_next  = 1;

  traffic_phase_scheduler #(
    .GREEN_MIN (GREEN_MIN),
    .GREEN_MAX (GREEN_MAX),
    .YELLOW_T  (YELLOW_T),
    .ALLRED_T  (ALLRED_T),
    .WALK_T    (WALK_T)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .car_a     (car_a),
    .car_b     (car_b),
    .ped_req   (ped_req),
    .emerg_req (emerg_req),
    .emerg_dir (emerg_dir),
    .light_A   (light_A),
    .light_B   (light_B),
    .walk      (walk),
    .phase     (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] lamp_a(input int p);
    if (p == PH_AG) return 3'b001;
    if (p == PH_AY) return 3'b010;
    return 3'b100;
  endfunction

  function automatic logic [2:0] lamp_b(input int p);
    if (p == PH_BG) return 3'b001;
    if (p == PH_BY) return 3'b010;
    return 3'b100;
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit ca, input bit cb,
                               input bit ped, input bit em, input bit ed);
    reset     = rst;
    car_a     = ca;
    car_b     = cb;
    ped_req   = ped;
    emerg_req = em;
    emerg_dir = ed;
  endtask

  // Literal expectation for the current second; pins both DUT and model.
  task automatic checkOutput(input string name, input int exp_phase);
    compare({name, ".phase"},   {29'd0, phase}, exp_phase);
    compare({name, ".model"},   m_phase, exp_phase);
    compare({name, ".light_A"}, {29'd0, light_A}, {29'd0, lamp_a(exp_phase)});
    compare({name, ".light_B"}, {29'd0, light_B}, {29'd0, lamp_b(exp_phase)});
    compare({name, ".walk"},    {31'd0, walk}, (exp_phase == PH_WALK) ? 1 : 0);
  endtask

  // Advance the model one second from the current inputs, then cross the edge.
  task automatic tick();
    int np;
    int nt;
    bit nped;
    bit nnext;
    int served;
    served = m_t + 1;
    np     = m_phase;
    nnext  = m_next;
    if (reset) begin
      np = PH_AG; nt = 0; nped = 0; nnext = 1;
    end else begin
      case (m_phase)
        PH_AG: begin
          if (emerg_req && emerg_dir) np = PH_AY;
          else if (!(emerg_req && !emerg_dir) && served >= GREEN_MIN && (car_b || m_ped)) np = PH_AY;
        end
        PH_BG: begin
          if (emerg_req && !emerg_dir) np = PH_BY;
          else if (!(emerg_req && emerg_dir) && served >= GREEN_MIN &&
                   (!car_b || m_ped || (car_a && served >= GREEN_MAX))) np = PH_BY;
        end
        PH_AY: if (served == YELLOW_T) begin np = PH_ARAB; nnext = 1; end
        PH_BY: if (served == YELLOW_T) begin np = PH_ARBA; nnext = 0; end
        PH_ARAB, PH_ARBA: begin
          if (served == ALLRED_T) begin
            if (emerg_req)  np = emerg_dir ? PH_BG : PH_AG;
            else if (m_ped) np = PH_WALK;
            else            np = m_next ? PH_BG : PH_AG;
          end
        end
        default: begin
          if (emerg_req)               np = emerg_dir ? PH_BG : PH_AG;
          else if (served == WALK_T)   np = m_next ? PH_BG : PH_AG;
        end
      endcase
      nt = (np != m_phase) ? 0 : ((m_t < 255) ? m_t + 1 : 255);
      if (np == PH_WALK && m_phase != PH_WALK) nped = 0;
      else nped = m_ped || (ped_req && m_phase != PH_WALK);
    end
    @(posedge clk);
    #1;
    m_phase = np;
    m_t     = nt;
    m_ped   = nped;
    m_next  = nnext;
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      compare($sformatf("phase@%0t", $time),   {29'd0, phase},   m_phase);
      compare($sformatf("light_A@%0t", $time), {29'd0, light_A}, {29'd0, lamp_a(m_phase)});
      compare($sformatf("light_B@%0t", $time), {29'd0, light_B}, {29'd0, lamp_b(m_phase)});
      compare($sformatf("walk@%0t", $time),    {31'd0, walk},    (m_phase == PH_WALK) ? 1 : 0);
      compare($sformatf("safety@%0t", $time),
              {31'd0, (light_A != 3'b100) && (light_B != 3'b100)}, 0);
    end
  end

  function automatic int sc_full(input int c);
    if (c <= 4)  return PH_AG;
    if (c <= 6)  return PH_AY;
    if (c == 7)  return PH_ARAB;
    if (c <= 17) return PH_BG;
    if (c <= 19) return PH_BY;
    if (c == 20) return PH_ARBA;
    return PH_AG;
  endfunction

  function automatic int sc_ped(input int c);
    if (c <= 4)  return PH_AG;
    if (c <= 6)  return PH_AY;
    if (c == 7)  return PH_ARAB;
    if (c <= 11) return PH_WALK;
    if (c <= 16) return PH_BG;
    if (c <= 18) return PH_BY;
    if (c == 19) return PH_ARBA;
    return PH_AG;
  endfunction

  function automatic int sc_emerg(input int c);
    if (c <= 1)  return PH_AG;
    if (c <= 3)  return PH_AY;
    if (c == 4)  return PH_ARAB;
    if (c <= 13) return PH_BG;
    return PH_BY;
  endfunction

  function automatic int sc_rst(input int c);
    if (c <= 4)  return PH_AG;
    if (c <= 6)  return PH_AY;
    if (c == 7)  return PH_ARAB;
    if (c <= 12) return PH_BG;
    if (c == 13) return PH_BY;
    return PH_AG;
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit em;
    bit ed;
    applyStimulus(1, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    tick();
    check_en = 1;

    $display("[TB] car_b demand, then car_a forcing GREEN_MAX");
    for (int c = 0; c < 22; c++) begin
      applyStimulus(0, c >= 8, 1, 0, 0, 0);
      checkOutput($sformatf("full_c%0d", c), sc_full(c));
      tick();
    end

    $display("[TB] idle rest on A, then late car_b");
    applyStimulus(1, 0, 0, 0, 0, 0);
    tick();
    for (int c = 0; c < 30; c++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput($sformatf("idle_c%0d", c), PH_AG);
      tick();
    end
    applyStimulus(1, 0, 0, 0, 0, 0);
    tick();
    for (int c = 0; c < 6; c++) begin
      applyStimulus(0, 0, c >= 2, 0, 0, 0);
      checkOutput($sformatf("late_b_c%0d", c), (c <= 4) ? PH_AG : PH_AY);
      tick();
    end

    $display("[TB] pedestrian pulse with a repeat inside WALK");
    applyStimulus(1, 0, 0, 0, 0, 0);
    tick();
    for (int c = 0; c < 24; c++) begin
      applyStimulus(0, 0, 0, (c == 0) || (c == 9), 0, 0);
      checkOutput($sformatf("ped_c%0d", c), sc_ped(c));
      tick();
    end

    $display("[TB] emergency preemption toward B");
    applyStimulus(1, 0, 0, 0, 0, 0);
    tick();
    for (int c = 0; c < 15; c++) begin
      applyStimulus(0, 0, 0, 0, (c >= 1) && (c <= 12), 1);
      checkOutput($sformatf("emerg_c%0d", c), sc_emerg(c));
      tick();
    end

    $display("[TB] reset during B yellow with a pending button");
    applyStimulus(1, 0, 0, 0, 0, 0);
    tick();
    for (int c = 0; c < 31; c++) begin
      applyStimulus(c == 13, 0, c < 10, c == 10, 0, 0);
      checkOutput($sformatf("rst_c%0d", c), sc_rst(c));
      tick();
    end

    $display("[TB] randomized traffic");
    em = 0;
    ed = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(39) == 0) begin
        em = ~em;
        ed = 1'($urandom_range(1));
      end
      applyStimulus($urandom_range(699) == 0,
                    $urandom_range(2) != 0,
                    $urandom_range(2) != 0,
                    $urandom_range(15) == 0,
                    em, ed);
      tick();
    end

    @(negedge clk);
    #1;
    check_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
